stage_execute: RTL and testbench
================================

// Module: stage_execute
// PURPOSE
//  Vector execute stage directly upstream of the writeback stage; produces its aluResult, address, imm,
//  writeData, writeEnable and writeRegFrom as registered EX/WB outputs.
//  Lane-parallel single-cycle ALU ops, plus an optional lane-serial multiply.
//  The multiply stalls the decode stage through a valid/ready handshake.
// PARAMETERS
//  vecSize       4  number of lanes per vector
//  registerSize  8  bits per lane; also the width of address and imm
// PORTS
//  clk              in   1                      clock; all state updates on rising edge
//  reset            in   1                      asynchronous, active-low reset
//  flush            in   1                      synchronous kill of in-flight and presented instruction
//  in_valid         in   1                      decode presents an instruction
//  in_ready         out  1                      stage can accept this cycle
//  aluOp            in   3                      alu_op_t
//  srcA, srcB       in   vecSize x registerSize operand vectors
//  imm_in           in   registerSize           immediate
//  writeEnable_in   in   1                      store request
//  writeRegFrom_in  in   2                      0 = mem, 1 = alu, 2 = imm
//  regDest_in       in   4                      destination register index
//  out_valid        out  1                      EX/WB outputs hold a valid instruction
//  aluResult        out  vecSize x registerSize ALU result
//  writeData        out  vecSize x registerSize store data (registered srcB)
//  address          out  registerSize           srcA[0] + imm_in, mod 2^registerSize
//  imm              out  registerSize           registered imm_in
//  writeEnable      out  1                      writeEnable_in & out_valid
//  writeRegFrom     out  2                      registered writeRegFrom_in
//  regDest          out  4                      registered regDest_in
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, lane counter 0; in_ready = 1 while in reset.
//  Handshake and state:
//   - in_ready = (state == IDLE). Accept = in_valid & in_ready & ~flush.
//   - Downstream never stalls.
//  Opcodes: per lane i:
//   - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: wrap mod 2^registerSize.
//   - 5 SLL, 6 SRL: shift srcA[i] by srcB[i][$clog2(registerSize)-1:0].
//   - 7 MUL: low registerSize bits of srcA[i] * srcB[i].
//  Latency:
//   - Ops 0-6: outputs registered at the edge after accept; out_valid high exactly 1 cycle.
//   - MUL: accept -> state MUL, operands captured, lane counter 0.
//     One lane per cycle; after lane vecSize-1, outputs load on the next edge. Latency = vecSize+1.
//  FSM: IDLE -(accept & MUL)-> MUL. MUL -(lane == vecSize-1)-> IDLE. MUL -(flush)-> IDLE.
//  out_valid:
//   - Deasserts the cycle after any cycle with no completion.
//   - Payload outputs hold their last value when out_valid = 0.
//  writeEnable is never 1 unless out_valid = 1; this protects data memory from bubbles.
//  flush:
//   - Next cycle out_valid = 0, writeEnable = 0.
//   - A MUL in flight is aborted: no out_valid, counter cleared.
//   - in_valid & flush in the same cycle: instruction dropped.
//  Reset mid-MUL: immediate return to IDLE; no partial result ever becomes valid.
//  MUL with vecSize = 1: latency 2.
// CONFIGURATION
//  Macro: STAGE_EXECUTE_VMUL_EN.
//   - Defined: MUL implemented as above.
//   - Undefined: MUL state and multiplier omitted; aluOp 7 is single-cycle and yields aluResult = 0;
//     in_ready is tied to 1.
// STRUCTURE
//  Package asip_pkg:
//   - alu_op_t enum (ADD..MUL)
//   - ex_state_t {IDLE, MUL}
//   - WB_FROM_MEM/ALU/IMM constants
//  Sub-module vector_alu: combinational, lane-parallel ops 0-6, instantiated once.
//  The multiplier datapath, FSM and EX/WB registers remain in stage_execute.
// TESTING
//  1 Reset low mid-traffic -> all outputs 0, in_ready = 1; release, then ADD of 8'hFF + 8'h02
//    on all lanes -> aluResult lanes 8'h01, out_valid for 1 cycle.
//  2 SLL srcA = 8'h81, srcB = 8'h09 (shamt 1) -> 8'h02; SRL same -> 8'h40;
//    XOR 8'hAA ^ 8'h0F -> 8'hA5.
//  3 MUL lanes {3,4,5,16} x {7,8,9,16} -> {21,32,45,0}; in_ready low 4 cycles; out_valid at
//    cycle 5; back-to-back ADD is accepted only after in_ready returns.
//  4 Store: writeEnable_in = 1, srcA[0] = 8'hF0, imm_in = 8'h20 -> address = 8'h10,
//    writeEnable = 1 for 1 cycle, writeData = srcB.
//  5 flush on cycle 2 of a MUL -> no out_valid, writeEnable stays 0, in_ready = 1 next cycle;
//    in_valid + flush same cycle -> dropped.
//  6 Build without STAGE_EXECUTE_VMUL_EN: aluOp 7 -> aluResult 0 at latency 1, in_ready constant 1.

Source files
------------

// File: rtl/asip_pkg.sv
// Shared types for the vector execute stage: ALU opcodes, EX FSM states and
// writeback source selectors.
package asip_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLL = 3'd5,
      ALU_SRL = 3'd6,
      ALU_MUL = 3'd7
   } alu_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } ex_state_t;

   localparam logic [1:0] WB_FROM_MEM = 2'd0;
   localparam logic [1:0] WB_FROM_ALU = 2'd1;
   localparam logic [1:0] WB_FROM_IMM = 2'd2;

endpackage

// File: rtl/stage_execute_if.sv
// Decode -> execute -> writeback bundle. The master modport is the decode/writeback
// side, and the slave modport is the execute stage.
interface stage_execute_if #(
   parameter int vecSize      = 4,
   parameter int registerSize = 8
);
   import asip_pkg::*;

   logic                                    in_valid;
   logic                                    in_ready;
   alu_op_t                                 aluOp;
   logic [vecSize-1:0][registerSize-1:0]    srcA;
   logic [vecSize-1:0][registerSize-1:0]    srcB;
   logic [registerSize-1:0]                 imm_in;
   logic                                    writeEnable_in;
   logic [1:0]                              writeRegFrom_in;
   logic [3:0]                              regDest_in;

   logic                                    out_valid;
   logic [vecSize-1:0][registerSize-1:0]    aluResult;
   logic [vecSize-1:0][registerSize-1:0]    writeData;
   logic [registerSize-1:0]                 address;
   logic [registerSize-1:0]                 imm;
   logic                                    writeEnable;
   logic [1:0]                              writeRegFrom;
   logic [3:0]                              regDest;

   modport master (
      output in_valid, aluOp, srcA, srcB, imm_in, writeEnable_in, writeRegFrom_in, regDest_in,
      input  in_ready, out_valid, aluResult, writeData, address, imm, writeEnable,
             writeRegFrom, regDest
   );

   modport slave (
      input  in_valid, aluOp, srcA, srcB, imm_in, writeEnable_in, writeRegFrom_in, regDest_in,
      output in_ready, out_valid, aluResult, writeData, address, imm, writeEnable,
             writeRegFrom, regDest
   );

endinterface

// File: rtl/vector_alu.sv
// Combinational lane-parallel ALU for the single-cycle opcodes (ADD..SRL).
// ALU_MUL yields zero here; the execute stage owns the multiplier.
module vector_alu
   import asip_pkg::*;
#(
   parameter int vecSize      = 4,
   parameter int registerSize = 8
) (
   input  alu_op_t                              op,
   input  logic [vecSize-1:0][registerSize-1:0] a,
   input  logic [vecSize-1:0][registerSize-1:0] b,
   output logic [vecSize-1:0][registerSize-1:0] y
);

   localparam int SHW = (registerSize > 1) ? $clog2(registerSize) : 1;

   always_comb begin
      // NOTE: default every output first so no path through the case infers a latch.
      y = '0;
      for (int i = 0; i < vecSize; i++) begin
         case (op)
            ALU_ADD: y[i] = a[i] + b[i];
            ALU_SUB: y[i] = a[i] - b[i];
            ALU_AND: y[i] = a[i] & b[i];
            ALU_OR:  y[i] = a[i] | b[i];
            ALU_XOR: y[i] = a[i] ^ b[i];
            ALU_SLL: y[i] = a[i] << b[i][SHW-1:0];
            ALU_SRL: y[i] = a[i] >> b[i][SHW-1:0];
            default: y[i] = '0;
         endcase
      end
   end

endmodule

// File: rtl/stage_execute.sv
// Vector execute stage with registered EX/WB outputs. Define STAGE_EXECUTE_VMUL_EN
// for the lane-serial multiply; without it, aluOp 7 is single-cycle and yields zero.
module stage_execute
   import asip_pkg::*;
#(
   parameter int vecSize      = 4,
   parameter int registerSize = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   stage_execute_if.slave  ex
);

   typedef logic [vecSize-1:0][registerSize-1:0] vec_t;
   typedef logic [registerSize-1:0]              word_t;

   logic  in_ready;
   logic  accept;
   vec_t  alu_y;

   logic        out_valid_q, out_valid_d;
   vec_t        alu_result_q, alu_result_d;
   vec_t        write_data_q, write_data_d;
   word_t       address_q, address_d;
   word_t       imm_q, imm_d;
   logic        we_q, we_d;
   logic [1:0]  from_q, from_d;
   logic [3:0]  dest_q, dest_d;

   vector_alu #(.vecSize(vecSize), .registerSize(registerSize)) u_alu (
      .op (ex.aluOp),
      .a  (ex.srcA),
      .b  (ex.srcB),
      .y  (alu_y)
   );

`ifdef STAGE_EXECUTE_VMUL_EN
   localparam int                LANE_W    = (vecSize > 1) ? $clog2(vecSize) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(vecSize - 1);

   ex_state_t          state_q, state_d;
   logic [LANE_W-1:0]  lane_q, lane_d;
   vec_t               mul_a_q, mul_a_d;
   vec_t               mul_b_q, mul_b_d;
   vec_t               mul_res_q, mul_res_d;
   word_t              pend_imm_q, pend_imm_d;
   logic               pend_we_q, pend_we_d;
   logic [1:0]         pend_from_q, pend_from_d;
   logic [3:0]         pend_dest_q, pend_dest_d;
   word_t              lane_prod;

   assign in_ready  = (state_q == IDLE);
   assign lane_prod = mul_a_q[lane_q] * mul_b_q[lane_q];
`else
   assign in_ready = 1'b1;
`endif

   assign accept = ex.in_valid & in_ready & ~flush;

   always_comb begin
      out_valid_d  = 1'b0;
      alu_result_d = alu_result_q;
      write_data_d = write_data_q;
      address_d    = address_q;
      imm_d        = imm_q;
      we_d         = we_q;
      from_d       = from_q;
      dest_d       = dest_q;
`ifdef STAGE_EXECUTE_VMUL_EN
      state_d      = state_q;
      lane_d       = lane_q;
      mul_a_d      = mul_a_q;
      mul_b_d      = mul_b_q;
      mul_res_d    = mul_res_q;
      pend_imm_d   = pend_imm_q;
      pend_we_d    = pend_we_q;
      pend_from_d  = pend_from_q;
      pend_dest_d  = pend_dest_q;

      if (accept && ex.aluOp != ALU_MUL) begin
`else
      if (accept) begin
`endif
         out_valid_d  = 1'b1;
         alu_result_d = alu_y;
         write_data_d = ex.srcB;
         address_d    = ex.srcA[0] + ex.imm_in;
         imm_d        = ex.imm_in;
         we_d         = ex.writeEnable_in;
         from_d       = ex.writeRegFrom_in;
         dest_d       = ex.regDest_in;
      end

`ifdef STAGE_EXECUTE_VMUL_EN
      case (state_q)
         IDLE: begin
            if (accept && ex.aluOp == ALU_MUL) begin
               state_d     = MUL;
               lane_d      = '0;
               mul_a_d     = ex.srcA;
               mul_b_d     = ex.srcB;
               pend_imm_d  = ex.imm_in;
               pend_we_d   = ex.writeEnable_in;
               pend_from_d = ex.writeRegFrom_in;
               pend_dest_d = ex.regDest_in;
            end
         end
         MUL: begin
            if (flush) begin
               state_d = IDLE;
               lane_d  = '0;
            end else begin
               mul_res_d[lane_q] = lane_prod;
               if (lane_q == LAST_LANE) begin
                  // Last lane's product goes straight into the EX/WB register.
                  state_d      = IDLE;
                  lane_d       = '0;
                  out_valid_d  = 1'b1;
                  alu_result_d = mul_res_d;
                  write_data_d = mul_b_q;
                  address_d    = mul_a_q[0] + pend_imm_q;
                  imm_d        = pend_imm_q;
                  we_d         = pend_we_q;
                  from_d       = pend_from_q;
                  dest_d       = pend_dest_q;
               end else begin
                  lane_d = lane_q + LANE_W'(1);
               end
            end
         end
      endcase
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q  <= 1'b0;
         alu_result_q <= '0;
         write_data_q <= '0;
         address_q    <= '0;
         imm_q        <= '0;
         we_q         <= 1'b0;
         from_q       <= '0;
         dest_q       <= '0;
`ifdef STAGE_EXECUTE_VMUL_EN
         state_q      <= IDLE;
         lane_q       <= '0;
         mul_a_q      <= '0;
         mul_b_q      <= '0;
         mul_res_q    <= '0;
         pend_imm_q   <= '0;
         pend_we_q    <= 1'b0;
         pend_from_q  <= '0;
         pend_dest_q  <= '0;
`endif
      end else begin
         out_valid_q  <= out_valid_d;
         alu_result_q <= alu_result_d;
         write_data_q <= write_data_d;
         address_q    <= address_d;
         imm_q        <= imm_d;
         we_q         <= we_d;
         from_q       <= from_d;
         dest_q       <= dest_d;
`ifdef STAGE_EXECUTE_VMUL_EN
         state_q      <= state_d;
         lane_q       <= lane_d;
         mul_a_q      <= mul_a_d;
         mul_b_q      <= mul_b_d;
         mul_res_q    <= mul_res_d;
         pend_imm_q   <= pend_imm_d;
         pend_we_q    <= pend_we_d;
         pend_from_q  <= pend_from_d;
         pend_dest_q  <= pend_dest_d;
`endif
      end
   end

   assign ex.in_ready     = in_ready;
   assign ex.out_valid    = out_valid_q;
   assign ex.aluResult    = alu_result_q;
   assign ex.writeData    = write_data_q;
   assign ex.address      = address_q;
   assign ex.imm          = imm_q;
   // Bubbles must never write data memory.
   assign ex.writeEnable  = we_q & out_valid_q;
   assign ex.writeRegFrom = from_q;
   assign ex.regDest      = dest_q;

endmodule

// File: tb/tb_stage_execute.sv
// Self-checking bench for stage_execute: table-driven single-cycle ops plus
// hand-written reset, flush and (with STAGE_EXECUTE_VMUL_EN) multiply sequences.
module tb_stage_execute;
   import asip_pkg::*;

   localparam int VS = 4;
   localparam int RS = 8;

   logic clk = 1'b0;
   logic reset;
   logic flush;

   always #5 clk = ~clk;

   stage_execute_if #(.vecSize(VS), .registerSize(RS)) ex ();

   stage_execute #(.vecSize(VS), .registerSize(RS)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .ex    (ex)
   );

   typedef struct {
      alu_op_t     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  imm;
      logic        we;
      logic [1:0]  from;
      logic [3:0]  dest;
      logic [31:0] exp_res;
      logic [7:0]  exp_addr;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ex.in_valid        = 1'b0;
      ex.aluOp           = ALU_ADD;
      ex.srcA            = '0;
      ex.srcB            = '0;
      ex.imm_in          = '0;
      ex.writeEnable_in  = 1'b0;
      ex.writeRegFrom_in = '0;
      ex.regDest_in      = '0;
   endtask

   task automatic drive(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] imm, input logic we, input logic [1:0] from,
                        input logic [3:0] dest);
      ex.in_valid        = 1'b1;
      ex.aluOp           = op;
      ex.srcA            = a;
      ex.srcB            = b;
      ex.imm_in          = imm;
      ex.writeEnable_in  = we;
      ex.writeRegFrom_in = from;
      ex.regDest_in      = dest;
   endtask

   task automatic add_vec(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] imm, input logic we, input logic [1:0] from,
                          input logic [3:0] dest, input logic [31:0] exp_res,
                          input logic [7:0] exp_addr);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.imm = imm; v.we = we; v.from = from; v.dest = dest;
      v.exp_res = exp_res; v.exp_addr = exp_addr;
      vecs.push_back(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Lanes written {lane3, lane2, lane1, lane0}; address = lane0 of srcA + imm.
      add_vec(ALU_ADD, 32'hFFFFFFFF, 32'h02020202, 8'h00, 1'b0, WB_FROM_ALU, 4'd1, 32'h01010101, 8'hFF);
      add_vec(ALU_SLL, 32'h81818181, 32'h09090909, 8'h03, 1'b0, WB_FROM_ALU, 4'd2, 32'h02020202, 8'h84);
      add_vec(ALU_SRL, 32'h81818181, 32'h09090909, 8'h00, 1'b0, WB_FROM_ALU, 4'd3, 32'h40404040, 8'h81);
      add_vec(ALU_XOR, 32'hAAAAAAAA, 32'h0F0F0F0F, 8'h01, 1'b0, WB_FROM_ALU, 4'd4, 32'hA5A5A5A5, 8'hAB);
      add_vec(ALU_SUB, 32'h00100580, 32'h01010501, 8'h00, 1'b0, WB_FROM_IMM, 4'd5, 32'hFF0F007F, 8'h80);
      add_vec(ALU_AND, 32'hF0F0F0F0, 32'h3C3C3C3C, 8'h10, 1'b0, WB_FROM_ALU, 4'd6, 32'h30303030, 8'h00);
      add_vec(ALU_OR,  32'h0F0F0F0F, 32'h30303030, 8'h00, 1'b0, WB_FROM_ALU, 4'd7, 32'h3F3F3F3F, 8'h0F);
      add_vec(ALU_ADD, 32'h000000F0, 32'h12345678, 8'h20, 1'b1, WB_FROM_MEM, 4'd8, 32'h12345668, 8'h10);
      add_vec(ALU_SLL, 32'h01FF0103, 32'h07000802, 8'h00, 1'b0, WB_FROM_ALU, 4'd9, 32'h80FF010C, 8'h03);
      add_vec(ALU_SRL, 32'h80808080, 32'h0F0F0F0F, 8'h00, 1'b0, WB_FROM_ALU, 4'hA, 32'h01010101, 8'h80);
`ifndef STAGE_EXECUTE_VMUL_EN
      add_vec(ALU_MUL, 32'h10050403, 32'h10090807, 8'h01, 1'b1, WB_FROM_ALU, 4'hB, 32'h00000000, 8'h04);
`endif

      idle_inputs();
      flush = 1'b0;
      reset = 1'b0;
      #1;
      check("reset in_ready", ex.in_ready, 1'b1);
      tick();
      tick();
      check("reset out_valid", ex.out_valid, 1'b0);
      check("reset aluResult", ex.aluResult, 32'h0);
      check("reset address", ex.address, 8'h00);
      check("reset writeEnable", ex.writeEnable, 1'b0);
      reset = 1'b1;
      tick();

      // Reset asserted while a store result is valid.
      drive(ALU_ADD, 32'hFFFFFFFF, 32'h02020202, 8'h05, 1'b1, WB_FROM_MEM, 4'd3);
      tick();
      check("pre-reset out_valid", ex.out_valid, 1'b1);
      reset = 1'b0;
      #2;
      check("midreset out_valid", ex.out_valid, 1'b0);
      check("midreset aluResult", ex.aluResult, 32'h0);
      check("midreset writeData", ex.writeData, 32'h0);
      check("midreset address", ex.address, 8'h00);
      check("midreset imm", ex.imm, 8'h00);
      check("midreset writeEnable", ex.writeEnable, 1'b0);
      check("midreset regDest", ex.regDest, 4'd0);
      check("midreset in_ready", ex.in_ready, 1'b1);
      tick();
      check("inreset out_valid", ex.out_valid, 1'b0);
      idle_inputs();
      reset = 1'b1;
      tick();

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].we, vecs[i].from,
               vecs[i].dest);
         check($sformatf("v%0d in_ready", i), ex.in_ready, 1'b1);
         tick();
         ex.in_valid = 1'b0;
         check($sformatf("v%0d out_valid", i), ex.out_valid, 1'b1);
         check($sformatf("v%0d aluResult", i), ex.aluResult, vecs[i].exp_res);
         check($sformatf("v%0d address", i), ex.address, vecs[i].exp_addr);
         check($sformatf("v%0d writeData", i), ex.writeData, vecs[i].b);
         check($sformatf("v%0d imm", i), ex.imm, vecs[i].imm);
         check($sformatf("v%0d writeEnable", i), ex.writeEnable, vecs[i].we);
         check($sformatf("v%0d writeRegFrom", i), ex.writeRegFrom, vecs[i].from);
         check($sformatf("v%0d regDest", i), ex.regDest, vecs[i].dest);
         tick();
         check($sformatf("v%0d out_valid drop", i), ex.out_valid, 1'b0);
         check($sformatf("v%0d writeEnable drop", i), ex.writeEnable, 1'b0);
         check($sformatf("v%0d aluResult hold", i), ex.aluResult, vecs[i].exp_res);
      end

      // Instruction presented together with flush is dropped.
      drive(ALU_ADD, 32'h11111111, 32'h22222222, 8'h00, 1'b1, WB_FROM_MEM, 4'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      idle_inputs();
      check("flushdrop out_valid", ex.out_valid, 1'b0);
      check("flushdrop writeEnable", ex.writeEnable, 1'b0);
      check("flushdrop in_ready", ex.in_ready, 1'b1);
      tick();
      check("flushdrop out_valid later", ex.out_valid, 1'b0);

`ifdef STAGE_EXECUTE_VMUL_EN
      // MUL {16,5,4,3} x {16,9,8,7}, then an ADD waiting behind it.
      drive(ALU_MUL, 32'h10050403, 32'h10090807, 8'h01, 1'b0, WB_FROM_ALU, 4'd9);
      tick();
      drive(ALU_ADD, 32'hFFFFFFFF, 32'h02020202, 8'h00, 1'b0, WB_FROM_ALU, 4'd2);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("mul busy%0d in_ready", k), ex.in_ready, 1'b0);
         check($sformatf("mul busy%0d out_valid", k), ex.out_valid, 1'b0);
         if (k < 3) tick();
      end
      tick();
      check("mul out_valid", ex.out_valid, 1'b1);
      check("mul aluResult", ex.aluResult, 32'h002D2015);
      check("mul address", ex.address, 8'h04);
      check("mul writeData", ex.writeData, 32'h10090807);
      check("mul regDest", ex.regDest, 4'd9);
      check("mul in_ready back", ex.in_ready, 1'b1);
      tick();
      idle_inputs();
      check("mul+add out_valid", ex.out_valid, 1'b1);
      check("mul+add aluResult", ex.aluResult, 32'h01010101);
      check("mul+add regDest", ex.regDest, 4'd2);
      tick();
      check("mul+add drop", ex.out_valid, 1'b0);

      // Flush on the second MUL cycle aborts it.
      drive(ALU_MUL, 32'h02020202, 32'h03030303, 8'h00, 1'b1, WB_FROM_MEM, 4'd4);
      tick();
      idle_inputs();
      check("mulflush busy", ex.in_ready, 1'b0);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("mulflush in_ready", ex.in_ready, 1'b1);
      check("mulflush out_valid", ex.out_valid, 1'b0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("mulflush idle%0d out_valid", k), ex.out_valid, 1'b0);
         check($sformatf("mulflush idle%0d writeEnable", k), ex.writeEnable, 1'b0);
      end

      // Reset during a MUL: no partial result afterwards.
      drive(ALU_MUL, 32'h05050505, 32'h05050505, 8'h00, 1'b1, WB_FROM_ALU, 4'd5);
      tick();
      idle_inputs();
      tick();
      reset = 1'b0;
      #2;
      check("mulreset in_ready", ex.in_ready, 1'b1);
      check("mulreset out_valid", ex.out_valid, 1'b0);
      tick();
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("mulreset idle%0d out_valid", k), ex.out_valid, 1'b0);
      end
      check("mulreset aluResult", ex.aluResult, 32'h0);
`else
      check("nomul in_ready", ex.in_ready, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
